// File: rtl/gray_pkg.sv
// Shared definitions for the binary/Gray converter: default width and
// width-agnostic 32-bit helper functions for code conversion and bit counting.
package gray_pkg;

    localparam int DEFAULT_WIDTH = 4;

    // Forward conversion: each Gray bit is the XOR of adjacent binary bits.
    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    // Reverse conversion: running XOR from the MSB down to each bit position.
    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b     = '0;
        b[31] = g[31];
        for (int i = 30; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // Number of set bits in a 32-bit word; 6 bits holds the maximum of 32.
    function automatic logic [5:0] popcount(input logic [31:0] v);
        logic [5:0] cnt;
        cnt = '0;
        for (int i = 0; i < 32; i++) begin
            cnt = cnt + {5'b0, v[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/gray_decode.sv
// Width-generic combinational Gray-to-binary decoder built as a
// prefix-XOR chain running from the MSB towards the LSB.
module gray_decode
    import gray_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] gray_i,
    output logic [WIDTH-1:0] bin_o
);

    // Accumulate the XOR of all Gray bits at or above each position.
    always_comb begin
        logic acc;
        bin_o = '0;
        acc   = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            acc      = acc ^ gray_i[i];
            bin_o[i] = acc;
        end
    end

endmodule

// File: rtl/binary_to_gray.sv
// Registered binary/Gray converter with a Gray-to-binary mode, a
// combinational forward tap, and a monitor that flags forward results
// changing by more than one bit between consecutive conversions.
module binary_to_gray
    import gray_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             mode,
    input  logic [WIDTH-1:0] b_in,
    output logic [WIDTH-1:0] g_out,
    output logic             out_valid,
    output logic [WIDTH-1:0] g_comb,
    output logic             step_err
);

    logic [WIDTH-1:0] fwdCode;
    logic [WIDTH-1:0] revCode;
    logic [WIDTH-1:0] result_d;
    logic [WIDTH-1:0] gOut_q;
    logic [WIDTH-1:0] history_q;
    logic             outValid_q;
    logic             stepErr_q;
    logic             stepErr_d;
    logic             histValid_q;
    logic [31:0]      diffWide;

    assign fwdCode = b_in ^ (b_in >> 1);

    gray_decode #(
        .WIDTH (WIDTH)
    ) uDecode (
        .gray_i (b_in),
        .bin_o  (revCode)
    );

    assign result_d = mode ? revCode : fwdCode;

    // Zero-extend the bit difference against the last forward result so the
    // shared 32-bit popcount can be reused for any width.
    always_comb begin
        diffWide               = '0;
        diffWide[WIDTH-1:0]    = fwdCode ^ history_q;
    end

    assign stepErr_d = histValid_q && (popcount(diffWide) > 6'd1);

    // Output, valid and history registers; mode-1 samples never touch history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gOut_q      <= '0;
            outValid_q  <= 1'b0;
            stepErr_q   <= 1'b0;
            history_q   <= '0;
            histValid_q <= 1'b0;
        end else if (in_valid) begin
            gOut_q     <= result_d;
            outValid_q <= 1'b1;
            if (!mode) begin
                stepErr_q   <= stepErr_d;
                history_q   <= fwdCode;
                histValid_q <= 1'b1;
            end else begin
                stepErr_q <= 1'b0;
            end
        end else begin
            outValid_q <= 1'b0;
            stepErr_q  <= 1'b0;
        end
    end

    assign g_out     = gOut_q;
    assign out_valid = outValid_q;
    assign step_err  = stepErr_q;
    assign g_comb    = fwdCode;

endmodule

// File: tb/tb_binary_to_gray.sv
// Directed self-checking bench for binary_to_gray at the default 4-bit width.
module tb_binary_to_gray;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       mode;
    logic [3:0] b_in;
    logic [3:0] g_out;
    logic       out_valid;
    logic [3:0] g_comb;
    logic       step_err;

    int checks;
    int errors;

    logic [3:0] sweepExp [16];

    binary_to_gray #(
        .WIDTH (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .mode      (mode),
        .b_in      (b_in),
        .g_out     (g_out),
        .out_valid (out_valid),
        .g_comb    (g_comb),
        .step_err  (step_err)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one sample, let it be captured, then settle just after the edge.
    task automatic applyStimulus(input logic v, input logic m, input logic [3:0] b);
        in_valid = v;
        mode     = m;
        b_in     = b;
        @(posedge clk);
        #1;
    endtask

    // Compare one observed value against its hand-computed expectation.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Check the full registered output triple in one call.
    task automatic checkRegs(input string tag, input logic [3:0] expG,
                             input logic expV, input logic expE);
        checkOutput({tag, "_g_out"},     {28'b0, g_out},     {28'b0, expG});
        checkOutput({tag, "_out_valid"}, {31'b0, out_valid}, {31'b0, expV});
        checkOutput({tag, "_step_err"},  {31'b0, step_err},  {31'b0, expE});
    endtask

    initial begin
        checks = 0;
        errors = 0;
        sweepExp = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
                     4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000};

        // Held in reset with the tap exercised: registers cleared, tap live.
        rst_n    = 1'b0;
        in_valid = 1'b0;
        mode     = 1'b0;
        b_in     = 4'b0111;
        #2;
        checkOutput("reset_tap_g_comb", {28'b0, g_comb}, 32'h4);
        checkRegs("reset", 4'b0000, 1'b0, 1'b0);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        checkRegs("reset_held_valid", 4'b0000, 1'b0, 1'b0);
        in_valid = 1'b0;
        rst_n    = 1'b1;

        // Forward sweep 0..15 including the all-ones to zero wrap.
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 1'b0, 4'(i));
            checkRegs($sformatf("sweep%0d", i), sweepExp[i], 1'b1, 1'b0);
        end
        applyStimulus(1'b1, 1'b0, 4'b0000);
        checkRegs("wrap", 4'b0000, 1'b1, 1'b0);

        // Reverse mode vectors.
        applyStimulus(1'b1, 1'b1, 4'b1000);
        checkRegs("rev1000", 4'b1111, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 4'b0100);
        checkRegs("rev0100", 4'b0111, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 4'b0011);
        checkRegs("rev0011", 4'b0010, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 4'b0000);
        checkRegs("rev0000", 4'b0000, 1'b1, 1'b0);

        // Multi-bit step: Gray 0001 then 0110, flagged for one cycle only.
        applyStimulus(1'b1, 1'b0, 4'b0001);
        checkRegs("step_a", 4'b0001, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 4'b0100);
        checkRegs("step_b", 4'b0110, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0, 4'b0000);
        checkRegs("step_clear", 4'b0110, 1'b0, 1'b0);

        // Bubble: result holds through idle cycles with junk inputs.
        applyStimulus(1'b1, 1'b0, 4'b0101);
        checkRegs("bubble_load", 4'b0111, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 4'b1010);
        checkRegs("bubble1", 4'b0111, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 4'b1111);
        checkRegs("bubble2", 4'b0111, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 4'b0011);
        checkRegs("bubble3", 4'b0111, 1'b0, 1'b0);

        // Reverse samples between forward ones leave history untouched.
        applyStimulus(1'b1, 1'b0, 4'b0110);
        checkRegs("hist_a", 4'b0101, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 4'b1100);
        checkRegs("hist_rev", 4'b1000, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 4'b0111);
        checkRegs("hist_b", 4'b0100, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 4'b0111);
        checkRegs("hist_same", 4'b0100, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 4'b1010);
        checkRegs("hist_jump", 4'b1111, 1'b1, 1'b1);

        // Async reset mid-stream, asserted between clock edges.
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, 1'b0, 4'(i));
        end
        checkRegs("pre_reset", 4'b0111, 1'b1, 1'b0);
        in_valid = 1'b1;
        b_in     = 4'b0110;
        #3;
        rst_n = 1'b0;
        #1;
        checkRegs("async_reset", 4'b0000, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        applyStimulus(1'b1, 1'b0, 4'b1111);
        checkRegs("post_reset_first", 4'b1000, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 4'b0000);
        checkRegs("post_reset_second", 4'b0000, 1'b1, 1'b0);

        // Tap follows b_in regardless of mode and valid.
        mode     = 1'b1;
        in_valid = 1'b0;
        b_in     = 4'b1011;
        #1;
        checkOutput("tap_1011", {28'b0, g_comb}, 32'hE);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/binary_to_gray.md
Name: binary_to_gray

Overview:
Parameterised, registered binary/Gray code converter with an optional reverse (Gray-to-binary) mode.
- Sits on counter/pointer paths (e.g. FIFO pointers crossing clock domains) where a registered, glitch-free Gray value is needed.
- Default width is 4 bits; the default mode is binary-to-Gray.
- A combinational tap gives the same-cycle forward conversion for legacy users.

Parameters:
WIDTH, 4, data width of b_in, g_out and g_comb (legal range 2..32).

Ports:
clk  input  1  single clock; all state updates on rising edge.
rst_n  input  1  asynchronous active-low reset; asserts asynchronously, deasserts synchronously to clk.
in_valid  input  1  b_in/mode are sampled this cycle.
mode  input  1  0 = binary-to-Gray, 1 = Gray-to-binary.
b_in  input  WIDTH  input code word.
g_out  output  WIDTH  registered converted word.
out_valid  output  1  g_out holds a new result this cycle.
g_comb  output  WIDTH  combinational binary-to-Gray of b_in, independent of mode/clk/reset.
step_err  output  1  registered; high for one cycle when consecutive mode-0 valid outputs differ in more than one bit.

Behaviour:
- Reset (rst_n=0, any time, including mid-stream):
  - g_out=0, out_valid=0, step_err=0.
  - The history register (last mode-0 output) and the history-valid flag are cleared.
- Forward conversion: g[WIDTH-1]=b[WIDTH-1]; g[i]=b[i+1]^b[i] (i.e. b ^ (b>>1)).
- Reverse conversion: b[WIDTH-1]=g[WIDTH-1]; b[i]=b[i+1]^g[i] (prefix XOR from the MSB down).
- Latency: exactly 1 cycle. When in_valid=1 at edge N, g_out=convert(b_in,mode) and out_valid=1 after edge N.
- When in_valid=0 at an edge: out_valid drops to 0; g_out holds its last value (no clear).
- Throughput: one conversion per cycle; back-to-back in_valid allowed. No backpressure, no ready signal.
- g_comb: purely combinational, always b_in ^ (b_in>>1). Ignores mode, in_valid and reset.
- step_err, updated at every edge where in_valid=1 and mode=0:
  - If history is valid, step_err = (popcount(new ^ history) > 1); otherwise step_err=0.
  - History is then set to the new value and history-valid set to 1.
  - Identical consecutive values (popcount 0) are not an error.
- step_err with other inputs:
  - At edges where in_valid=0, or mode=1: step_err=0.
  - mode=1 cycles do not touch the history.
- Wrap-around: Gray of all-ones followed by Gray of 0 differs in 1 bit (MSB only) → no error.
- mode changing between consecutive valid cycles is legal; each sample is converted per its own mode bit.
- No X propagation from unused inputs: when in_valid=0, b_in and mode are don't-care.

Decomposition:
- Shared package gray_pkg contains:
  - DEFAULT_WIDTH=4.
  - Function bin2gray(logic [31:0]) (XOR-shift).
  - Function gray2bin(logic [31:0]) (loop prefix XOR).
  - Function popcount.
- One natural sub-module: gray_decode (WIDTH-generic combinational prefix-XOR chain), used for mode=1.
- The top instantiates gray_decode and holds the output, valid and history registers.

Test Plan:
1. Reset then exhaustive forward sweep: mode=0, in_valid=1, b_in=0..15 on consecutive cycles.
   - g_out one cycle later: 0000,0001,0011,0010,0110,0111,0101,0100,1100,1101,1111,1110,1010,1011,1001,1000.
   - step_err stays 0 throughout, including the 1111→0000 wrap.
2. Reverse mode: mode=1 with g inputs 1000, 0100, 0011, 0000 → g_out 1111, 0111, 0010, 0000; step_err=0.
3. Combinational tap: b_in=0111 with rst_n=0 and in_valid=0 → g_comb=0100 in the same cycle; g_out=0, out_valid=0.
4. Step error: mode=0 valid inputs b=0001 then b=0100 (Gray 0001→0110, 3 bits differ) → step_err=1 for exactly one cycle after the second edge.
5. Bubble: valid b=0101 (g_out=0111), then in_valid=0 for 3 cycles → out_valid=0, g_out holds 0111.
6. Async reset mid-stream: assert rst_n low between edges during the sweep.
   - g_out=0, out_valid=0 immediately, without waiting for a clock edge.
   - After release, the first valid input produces step_err=0 because history was cleared.
